// File: rtl/bnn_layer_seq_if.sv
// bnn_layer_seq_if: bundle of all handshake and load-stream signals of
// bnn_layer_seq.
//   master : the side that supplies input vectors, consumes results and
//            streams weight/threshold nibbles (a testbench or upstream layer).
//   slave  : the layer itself.
// Signals:
//   in_data/in_valid/in_ready    input vector channel
//   out_data/out_valid/out_ready result channel
//   ld_en/ld_nibble/ld_done      nibble load stream, ld_done pulses at stream end
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high; valid, once raised, holds its data
// stable until that edge.
interface bnn_layer_seq_if #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 4
);
   logic [N_IN-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic [N_OUT-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             ld_en;
   logic [3:0]       ld_nibble;
   logic             ld_done;

   modport master (
      output in_data, in_valid, out_ready, ld_en, ld_nibble,
      input  in_ready, out_data, out_valid, ld_done
   );

   modport slave (
      input  in_data, in_valid, out_ready, ld_en, ld_nibble,
      output in_ready, out_data, out_valid, ld_done
   );
endinterface

// File: rtl/bnn_layer_seq.sv
// bnn_layer_seq: time-multiplexed binary neural-network layer. One shared
// XNOR-popcount/threshold datapath evaluates N_OUT neurons, one per cycle,
// over an N_IN-bit binary input vector held in x_reg.
// Ports:
//   clk        clock
//   reset      asynchronous, active-high
//   ena        global enable; low freezes every register (no transfer completes)
//   bus        bnn_layer_seq_if.slave (input vector, result, nibble load stream)
//   fsm_state  current FSM state, for debug/observation
// Configuration macro: BNN_THRESH_LOAD_EN -- when defined, the load stream
// carries N_OUT two-nibble threshold words after the weight words; when
// undefined every neuron uses the constant THRESH.
module bnn_layer_seq #(
   parameter int N_IN   = 8,
   parameter int N_OUT  = 4,
   parameter int THRESH = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ena,
   bnn_layer_seq_if.slave  bus,
   output logic [1:0]      fsm_state
);
   localparam int CW    = $clog2(N_IN + 1);
   localparam int NNIB  = N_IN / 4;
   localparam int NIB_W = (NNIB > 1) ? $clog2(NNIB) : 1;
   localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int PW    = $clog2(2 * N_OUT);
`ifdef BNN_THRESH_LOAD_EN
   localparam int N_WORDS = 2 * N_OUT;
`else
   localparam int N_WORDS = N_OUT;
`endif
   localparam logic [CW-1:0] THR_C = CW'(THRESH);

   typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, HOLD = 2'd2} state_t;
   state_t state, state_nx;

   logic [N_IN-1:0]  x_reg;
   logic [IW-1:0]    idx;
   logic [N_OUT-1:0] out_reg;
   logic             out_valid_r;
   logic             ld_done_r;
   logic [N_IN-1:0]  wbuf;
   logic [NIB_W-1:0] nib_cnt;
   logic [PW-1:0]    ptr;
   logic [N_IN-1:0]  w [N_OUT];
`ifdef BNN_THRESH_LOAD_EN
   logic [CW-1:0]    thr [N_OUT];
`endif

   logic             accept;
   logic             ld_take;
   logic             last_nib;
   logic             final_word;
   logic [N_IN-1:0]  new_word;
   logic [N_IN-1:0]  xn;
   logic [CW-1:0]    pc;
   logic [CW-1:0]    thr_cur;

   // Loading has priority: in_ready drops whenever ld_en is high. It is also
   // gated by ena and reset so a visible valid&&ready always means a transfer.
   assign bus.in_ready  = (state == IDLE) && !bus.ld_en && ena && !reset;
   assign accept        = bus.in_valid && bus.in_ready;
   assign ld_take       = ena && (state == IDLE) && bus.ld_en;
   assign final_word    = (ptr == PW'(N_WORDS - 1));
   assign bus.out_data  = out_reg;
   assign bus.out_valid = out_valid_r;
   assign bus.ld_done   = ld_done_r;
   assign fsm_state     = state;

`ifdef BNN_THRESH_LOAD_EN
   // Pointer values N_OUT.. address threshold words, which are two nibbles long.
   assign last_nib = (ptr >= PW'(N_OUT)) ? (nib_cnt == NIB_W'(1))
                                         : (nib_cnt == NIB_W'(NNIB - 1));
   assign thr_cur  = thr[idx];
`else
   assign last_nib = (nib_cnt == NIB_W'(NNIB - 1));
   assign thr_cur  = THR_C;
`endif

   // Complete word as it would look with the current nibble merged in.
   always_comb begin
      new_word = wbuf;
      new_word[{nib_cnt, 2'b00} +: 4] = bus.ld_nibble;
   end

   always_comb begin
      pc = '0;
      xn = ~(x_reg ^ w[idx]);
      for (int j = 0; j < N_IN; j++) begin
         pc = pc + CW'(xn[j]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (ena) begin
         unique case (state)
            IDLE:    if (accept) state_nx = COMPUTE;
            COMPUTE: if (idx == IW'(N_OUT - 1)) state_nx = HOLD;
            HOLD:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_reg       <= '0;
         idx         <= '0;
         out_reg     <= '0;
         out_valid_r <= 1'b0;
         ld_done_r   <= 1'b0;
         wbuf        <= '0;
         nib_cnt     <= '0;
         ptr         <= '0;
         for (int i = 0; i < N_OUT; i++) begin
            w[i] <= '0;
`ifdef BNN_THRESH_LOAD_EN
            thr[i] <= THR_C;
`endif
         end
      end else if (ena) begin
         ld_done_r <= 1'b0;
         if (accept) begin
            x_reg <= bus.in_data;
            idx   <= '0;
         end
         if (state == COMPUTE) begin
            out_reg[idx] <= (pc >= thr_cur);
            idx          <= idx + 1'b1;
            if (idx == IW'(N_OUT - 1)) out_valid_r <= 1'b1;
         end
         if ((state == HOLD) && bus.out_ready) out_valid_r <= 1'b0;
         if (ld_take) begin
            if (last_nib) begin
               nib_cnt <= '0;
               if (ptr < PW'(N_OUT)) w[IW'(ptr)] <= new_word;
`ifdef BNN_THRESH_LOAD_EN
               else thr[IW'(ptr - PW'(N_OUT))] <= new_word[CW-1:0];
`endif
               ptr       <= final_word ? '0 : ptr + 1'b1;
               ld_done_r <= final_word;
            end else begin
               wbuf    <= new_word;
               nib_cnt <= nib_cnt + 1'b1;
            end
         end
      end
   end
endmodule
